// File: rtl/vt_clk_pkg.sv
// Shared clocking definitions: supervisor state encoding, default parameters
// and the saturating retry-counter helper.
package vt_clk_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_sup_state_t;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int RETRY_W          = 8;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    if (v == {RETRY_W{1'b1}}) begin
      return v;
    end else begin
      return v + RETRY_W'(1);
    end
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Generic N-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift chain; the first flop is the only one that can go metastable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset/lock sequencer gating the downstream reset on qualified lock.
// Build option: define PLL_SUP_RETRY_EN to enable lock timeout and PLL re-reset.
module pll_supervisor
  import vt_clk_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CNT_W   = ($clog2(MAX_CNT) < 1) ? 1 : $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE - 1);
`ifdef PLL_SUP_RETRY_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  pll_sup_state_t   state;
  pll_sup_state_t   next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             locked_s;
  logic             retry_inc;
  logic             lost_evt;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  // Next-state and event decode; restart outranks lock loss, which outranks expiry.
  always_comb begin
    next_state = state;
    retry_inc  = 1'b0;
    lost_evt   = 1'b0;
    if (restart) begin
      next_state = RESET_PLL;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            next_state = WAIT_LOCK;
          end else begin
            next_state = RESET_PLL;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            next_state = STABLE;
          end
`ifdef PLL_SUP_RETRY_EN
          else if (cnt == TO_LAST) begin
            next_state = RESET_PLL;
            retry_inc  = 1'b1;
          end
`endif
          else begin
            next_state = WAIT_LOCK;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            next_state = WAIT_LOCK;
          end else if (cnt == LS_LAST) begin
            next_state = RUN;
          end else begin
            next_state = STABLE;
          end
        end
        RUN: begin
          if (!locked_s) begin
            lost_evt   = 1'b1;
`ifdef PLL_SUP_RETRY_EN
            next_state = RESET_PLL;
            retry_inc  = 1'b1;
`else
            next_state = WAIT_LOCK;
`endif
          end else begin
            next_state = RUN;
          end
        end
        default: begin
          next_state = RESET_PLL;
        end
      endcase
    end
    // A restart re-enters RESET_PLL even from RESET_PLL, so it clears too.
    if (restart || (next_state != state)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // State, counter and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      pll_rst     <= (next_state == RESET_PLL);
      sys_rst_n   <= (next_state == RUN);
      lock_lost   <= lost_evt;
      if (retry_inc) begin
        retry_count <= sat_inc(retry_count);
      end else begin
        retry_count <= retry_count;
      end
    end
  end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Sequencer on the control side of the clock-generation PLL. It drives the PLL's `rst` input, consumes its asynchronous `locked` output, and decides when the rest of the terminal logic may leave reset. It pulses the PLL reset, waits for lock with a timeout, requires lock to stay stable for a qualification period, then releases `sys_rst_n`. Loss of lock restarts the sequence. It runs on the PLL reference clock (50 MHz), which is valid before lock.

## Interface
Parameters:
- `RST_CYCLES`, 16: width of the PLL reset pulse in clocks; must be ≥1.
- `LOCK_STABLE`, 1024: clocks `locked` must stay high before release; must be ≥1.
- `LOCK_TIMEOUT`, 50000: clocks to wait for lock before re-resetting the PLL; must be ≥1.
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked`; must be ≥2.

Ports:
- `clk`, in, 1: reference clock, same net as the PLL `refclk`.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `pll_locked`, in, 1: PLL `locked`, asynchronous to `clk`.
- `restart`, in, 1: synchronous single-cycle request to re-run the full sequence.
- `pll_rst`, out, 1: drives the PLL `rst`, active-high.
- `sys_rst_n`, out, 1: downstream reset, active-low.
- `lock_lost`, out, 1: one-cycle pulse on loss of lock in RUN.
- `retry_count`, out, 8: saturating count of timeouts plus lock losses.

## Operation
- The FSM has four states: RESET_PLL, WAIT_LOCK, STABLE, RUN. A single counter `cnt` is cleared on every state entry.
- `locked_s` is `pll_locked` passed through `SYNC_STAGES` flops. The FSM uses only `locked_s`.
- On reset: state=RESET_PLL, cnt=0, synchronizer=0, `pll_rst`=1, `sys_rst_n`=0, `lock_lost`=0, `retry_count`=0.
- RESET_PLL: `pll_rst`=1. When cnt==RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - If `locked_s`, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1, go to RESET_PLL and increment `retry_count`.
- STABLE:
  - If `!locked_s`, go to WAIT_LOCK. No retry increment; the timeout window starts again.
  - Else if cnt==LOCK_STABLE-1, go to RUN.
- RUN: `sys_rst_n`=1. If `!locked_s`, go to RESET_PLL, pulse `lock_lost`, and increment `retry_count`.
- `restart` is accepted in any state. It forces RESET_PLL and does not touch `lock_lost` or `retry_count`.
- Priority order: `restart` > lock loss > counter expiry.
- `retry_count` saturates at 255.
- `cnt` width is `$clog2` of the largest of the three count parameters.
- All outputs come straight from registers; none are driven combinationally from inputs.

## Timing
- Edge 0 is the first clock edge that samples `pll_locked`=1.
  - `locked_s`=1 after edge SYNC_STAGES-1.
  - The FSM enters STABLE at edge SYNC_STAGES.
  - `sys_rst_n`=1 after edge SYNC_STAGES+LOCK_STABLE.
- From `reset_n` deassertion, `pll_rst` stays high for exactly RST_CYCLES edges.
- RUN exit on lock loss:
  - `sys_rst_n`=0, `lock_lost`=1 and `pll_rst`=1 all take effect on the same edge, SYNC_STAGES edges after the low sample.
  - `lock_lost` returns to 0 on the next edge.
- `restart` sampled high at edge n gives `pll_rst`=1 and `sys_rst_n`=0 after edge n.
- Asserting `reset_n` in any state forces all reset values immediately, without waiting for a clock edge.

## Configuration
- `PLL_SUP_RETRY_EN` defined:
  - WAIT_LOCK timeout is active.
  - Lock loss in RUN goes to RESET_PLL.
  - `retry_count` counts as described in Operation.
- `PLL_SUP_RETRY_EN` undefined:
  - There is no timeout; WAIT_LOCK waits indefinitely.
  - Lock loss in RUN goes to WAIT_LOCK with `pll_rst` held 0. `lock_lost` still pulses.
  - `retry_count` is tied to 0.
  - `LOCK_TIMEOUT` is ignored.

## Structure
- Shared package `vt_clk_pkg`:
  - `pll_sup_state_t` enum.
  - Default parameter constants.
  - `RETRY_W`=8.
- Sub-module `sync_bit`: a generic N-flop synchronizer with parameter STAGES, reset to 0. It is reused for other asynchronous inputs.

## Test plan
All cases use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, SYNC_STAGES=2.
1. Release `reset_n` with `pll_locked`=0. Required: `pll_rst` high for 4 edges, then low for 32 edges, then high again. `retry_count`=1. `sys_rst_n` stays 0.
2. Raise `pll_locked` 10 cycles into WAIT_LOCK and hold it. Required: `sys_rst_n` rises after edge 10 from the first sampled high, and `retry_count` stays 0.
3. In STABLE, drop `pll_locked` for 3 cycles, then restore it. Required: `sys_rst_n` stays 0 and rises 10 edges after the restore. No retry increment.
4. In RUN, drop `pll_locked`. Required:
   - 2 edges later, `sys_rst_n`=0 and `lock_lost`=1 for exactly one cycle.
   - `pll_rst`=1 for 4 edges.
   - `retry_count` increments by 1.
5. In RUN, pulse `restart`. Required: `pll_rst`=1 and `sys_rst_n`=0 on the next edge, with `lock_lost`=0 and `retry_count` unchanged. Then assert `reset_n` mid-WAIT_LOCK. Required: outputs take their reset values immediately, before any clock edge.
6. Force 300 timeouts. Required: `retry_count` saturates at 255. With `PLL_SUP_RETRY_EN` undefined, `pll_rst` never reasserts after the initial pulse.
